// File: rtl/ch_seq_pkg.sv
// Shared types and sizing helpers for the channel sequencer.
package ch_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam int NCH_DEF   = 8;
   localparam int OVR_W_DEF = 8;

   // Smallest index width able to address nch channels (never below 1 bit).
   function automatic int sel_w_for(input int nch);
      return (nch <= 2) ? 1 : $clog2(nch);
   endfunction

   // Saturation value of an ovr_w-bit overrun counter.
   function automatic longint unsigned ovr_sat(input int ovr_w);
      return (longint'(1) << ovr_w) - 1;
   endfunction

endpackage

// File: rtl/ch_next_find.sv
// Combinational search over a channel mask: next set index above cur and lowest set index.
module ch_next_find
   import ch_seq_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int SEL_W = sel_w_for(NCH)
) (
   input  logic [NCH-1:0]   i_mask,
   input  logic [SEL_W-1:0] i_cur,
   output logic [SEL_W-1:0] o_nxt,
   output logic             o_found,
   output logic [SEL_W-1:0] o_low
);

   // Descending scan so the last hit is the smallest qualifying index.
   always_comb begin
      o_nxt   = '0;
      o_found = 1'b0;
      o_low   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (i_mask[i] && (i > int'(i_cur))) begin
            o_nxt   = SEL_W'(i);
            o_found = 1'b1;
         end
         if (i_mask[i]) begin
            o_low = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/ch_seq.sv
// Masked, back-pressured channel sequencer with overrun reporting.
//   state   | meaning
//   ST_IDLE | no scan; waiting for a qualified strobe with a non-zero mask
//   ST_SCAN | presenting one channel per accepted beat from the latched mask
module ch_seq
   import ch_seq_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int SEL_W = sel_w_for(NCH),
   parameter int OVR_W = OVR_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             strobe,
   input  logic             en,
   input  logic [NCH-1:0]   ch_mask,
   input  logic             ready,
   output logic             req_data,
   output logic [SEL_W-1:0] sel,
   output logic             first,
   output logic             last,
   output logic             busy,
   output logic             overrun,
   output logic [OVR_W-1:0] ovr_count
);

   localparam logic [OVR_W-1:0] OVR_MAX = OVR_W'(ovr_sat(OVR_W));

   state_t           r_state;
   logic [NCH-1:0]   r_mask;
   logic [SEL_W-1:0] r_sel;
   logic             r_overrun;
   logic [OVR_W-1:0] r_ovr_count;

   state_t           w_state_nxt;
   logic [NCH-1:0]   w_mask_nxt;
   logic [SEL_W-1:0] w_sel_nxt;
   logic             w_overrun_nxt;
   logic [OVR_W-1:0] w_ovr_count_nxt;

   logic             w_go;
   logic             w_scan;
   logic [NCH-1:0]   w_find_mask;
   logic [SEL_W-1:0] w_nxt;
   logic             w_found;
   logic [SEL_W-1:0] w_low;

   assign w_go   = strobe & en;
   assign w_scan = (r_state == ST_SCAN);

   // One finder serves both the start-of-scan lookup (live mask) and the in-scan walk.
   assign w_find_mask = w_scan ? r_mask : ch_mask;

   ch_next_find #(
      .NCH   (NCH),
      .SEL_W (SEL_W)
   ) u_find (
      .i_mask  (w_find_mask),
      .i_cur   (r_sel),
      .o_nxt   (w_nxt),
      .o_found (w_found),
      .o_low   (w_low)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_mask_nxt      = r_mask;
      w_sel_nxt       = r_sel;
      w_overrun_nxt   = 1'b0;
      w_ovr_count_nxt = r_ovr_count;
      case (r_state)
         ST_IDLE: begin
            if (w_go && (|ch_mask)) begin
               w_mask_nxt  = ch_mask;
               w_sel_nxt   = w_low;
               w_state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (ready) begin
               if (w_found) begin
                  w_sel_nxt = w_nxt;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            if (w_go) begin
               w_overrun_nxt = 1'b1;
               if (r_ovr_count != OVR_MAX) begin
                  w_ovr_count_nxt = r_ovr_count + 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_mask      <= '0;
         r_sel       <= '0;
         r_overrun   <= 1'b0;
         r_ovr_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mask      <= w_mask_nxt;
         r_sel       <= w_sel_nxt;
         r_overrun   <= w_overrun_nxt;
         r_ovr_count <= w_ovr_count_nxt;
      end
   end

   assign req_data  = w_scan;
   assign busy      = w_scan;
   assign sel       = r_sel;
   assign first     = w_scan & (r_sel == w_low);
   assign last      = w_scan & ~w_found;
   assign overrun   = r_overrun;
   assign ovr_count = r_ovr_count;

endmodule

// File: tb/tb_ch_seq.sv
// Directed vector bench for ch_seq: table-driven beats plus overrun, saturation and reset sequences.
module tb_ch_seq;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       strobe;
   logic       en;
   logic [7:0] ch_mask;
   logic       ready;

   logic       req_data, first, last, busy, overrun;
   logic [2:0] sel;
   logic [7:0] ovr_count;

   logic       req_data2, first2, last2, busy2, overrun2;
   logic [2:0] sel2;
   logic [1:0] ovr_count2;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ch_seq #(.NCH(8), .SEL_W(3), .OVR_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .strobe(strobe), .en(en), .ch_mask(ch_mask),
      .ready(ready), .req_data(req_data), .sel(sel), .first(first), .last(last),
      .busy(busy), .overrun(overrun), .ovr_count(ovr_count)
   );

   ch_seq #(.NCH(8), .SEL_W(3), .OVR_W(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .strobe(strobe), .en(en), .ch_mask(ch_mask),
      .ready(ready), .req_data(req_data2), .sel(sel2), .first(first2), .last(last2),
      .busy(busy2), .overrun(overrun2), .ovr_count(ovr_count2)
   );

   typedef struct {
      logic       stb;
      logic       en;
      logic [7:0] mask;
      logic       rdy;
      logic       req;
      logic [2:0] sel;
      logic       fst;
      logic       lst;
      logic       ovr;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic stb, input logic e, input logic [7:0] m,
                               input logic rdy, input logic req, input logic [2:0] s,
                               input logic f, input logic l, input logic o);
      vec_t v;
      v.stb = stb; v.en = e; v.mask = m; v.rdy = rdy;
      v.req = req; v.sel = s; v.fst = f; v.lst = l; v.ovr = o;
      tv.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; strobe = 1'b0; en = 1'b1; ch_mask = '0; ready = 1'b1;
      tick(); tick();
      chk("reset_outs", {req_data, busy, sel, first, last, overrun}, 8'h00);
      chk("reset_cnt", ovr_count, 0);
      reset_n = 1'b1;
      tick();

      // full mask, one beat per cycle
      add(1,1,8'hFF,1, 1,0,1,0,0);
      for (int i = 1; i < 7; i++) add(0,1,8'hFF,1, 1,3'(i),0,0,0);
      add(0,1,8'hFF,1, 1,7,0,1,0);
      add(0,1,8'hFF,1, 0,7,0,0,0);
      // sparse mask
      add(1,1,8'hA4,1, 1,2,1,0,0);
      add(0,1,8'hA4,1, 1,5,0,0,0);
      add(0,1,8'hA4,1, 1,7,0,1,0);
      add(0,1,8'hA4,1, 0,7,0,0,0);
      // single channel
      add(1,1,8'h10,1, 1,4,1,1,0);
      add(0,1,8'h10,1, 0,4,0,0,0);
      // back-pressure, en dropped mid-scan
      add(1,1,8'h0F,1, 1,0,1,0,0);
      add(0,1,8'h0F,1, 1,1,0,0,0);
      add(0,1,8'h0F,0, 1,1,0,0,0);
      add(0,1,8'h0F,0, 1,1,0,0,0);
      add(0,0,8'h0F,0, 1,1,0,0,0);
      add(0,0,8'h0F,1, 1,2,0,0,0);
      add(0,1,8'h0F,1, 1,3,0,1,0);
      add(0,1,8'h0F,1, 0,3,0,0,0);
      // zero mask and disabled strobe are ignored
      add(1,1,8'h00,1, 0,3,0,0,0);
      add(1,0,8'hFF,1, 0,3,0,0,0);
      // overruns mid-scan and on the last beat; mask change mid-scan ignored
      add(1,1,8'h07,1, 1,0,1,0,0);
      add(1,1,8'h07,1, 1,1,0,0,1);
      add(0,1,8'hFF,1, 1,2,0,1,0);
      add(1,1,8'h07,1, 0,2,0,0,1);
      add(1,1,8'h07,1, 1,0,1,0,0);
      add(0,1,8'h00,1, 1,1,0,0,0);
      add(0,1,8'h07,1, 1,2,0,1,0);
      add(0,1,8'h07,1, 0,2,0,0,0);

      for (int k = 0; k < tv.size(); k++) begin
         strobe = tv[k].stb; en = tv[k].en; ch_mask = tv[k].mask; ready = tv[k].rdy;
         tick();
         chk($sformatf("vec%0d", k), {req_data, busy, sel, first, last, overrun},
             {tv[k].req, tv[k].req, tv[k].sel, tv[k].fst, tv[k].lst, tv[k].ovr});
      end
      strobe = 1'b0; en = 1'b1;
      chk("ovr_cnt_2", ovr_count, 2);
      chk("ovr_cnt2_2", ovr_count2, 2);

      // five more drops while stalled: wide counter 7, 2-bit counter saturates at 3
      strobe = 1'b1; ch_mask = 8'hFF; ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      strobe = 1'b0;
      chk("stall_hold", {req_data, sel, first, last}, {1'b1, 3'd0, 1'b1, 1'b0});
      chk("ovr_cnt_7", ovr_count, 7);
      chk("ovr_cnt2_sat", ovr_count2, 3);
      tick();
      chk("ovr_pulse_end", overrun, 0);
      ready = 1'b1;
      for (int i = 0; i < 20 && req_data; i++) tick();
      chk("drain", req_data, 0);

      // async reset mid-scan
      strobe = 1'b1; ch_mask = 8'hFF;
      tick();
      strobe = 1'b0;
      tick(); tick(); tick();
      chk("pre_reset_sel", sel, 3);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_outs", {req_data, busy, sel, first, last, overrun}, 8'h00);
      chk("async_rst_cnt", ovr_count, 0);
      reset_n = 1'b1;
      tick();
      strobe = 1'b1; ch_mask = 8'h18;
      tick();
      strobe = 1'b0;
      chk("restart_first", {req_data, sel, first, last}, {1'b1, 3'd3, 1'b1, 1'b0});
      tick();
      chk("restart_last", {req_data, sel, first, last}, {1'b1, 3'd4, 1'b0, 1'b1});
      tick();
      chk("restart_done", req_data, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
